// File: rtl/mont_bitserial_mul.sv
// rtl/mont_bitserial_mul.sv - radix-2 Montgomery multiplier, A*B*2^-WIDTH mod M, A streamed LSB first
module mont_bitserial_mul #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   input  logic             a_bit,
   input  logic             a_valid,
   output logic             a_ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = WIDTH + 2;

   typedef enum logic [1:0] {IDLE, ACCUM, REDUCE} state_t;

   state_t           state;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] m_q;
   logic [SW-1:0]    s_acc;
   logic [CW-1:0]    cnt;

   logic [SW-1:0]    t_add;
   logic [SW-1:0]    t_odd;
   logic [SW-1:0]    s_sub;

   // S < 2m and b < m keep S + b + m below 2^(WIDTH+2), so no carry is lost.
   always_comb begin
      t_add = s_acc + (a_bit ? {2'b00, b_q} : {SW{1'b0}});
      t_odd = t_add[0] ? t_add + {2'b00, m_q} : t_add;
      s_sub = s_acc - {2'b00, m_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         b_q     <= '0;
         m_q     <= '0;
         s_acc   <= '0;
         cnt     <= '0;
         a_ready <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  b_q     <= b;
                  m_q     <= m;
                  s_acc   <= '0;
                  cnt     <= '0;
                  a_ready <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               if (a_valid) begin
                  s_acc <= t_odd >> 1;
                  cnt   <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH - 1)) begin
                     a_ready <= 1'b0;
                     state   <= REDUCE;
                  end
               end
            end
            REDUCE: begin
               result <= (s_acc >= {2'b00, m_q}) ? WIDTH'(s_sub) : WIDTH'(s_acc);
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               a_ready <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mont_bitserial_mul.sv
// tb/tb_mont_bitserial_mul.sv - scoreboard bench for mont_bitserial_mul at WIDTH=4 and WIDTH=20
module tb_mont_bitserial_mul;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start4, a_bit4, a_valid4, a_ready4, busy4, done4;
   logic [3:0]  b4, m4, result4;
   logic        start20, a_bit20, a_valid20, a_ready20, busy20, done20;
   logic [19:0] b20, m20, result20;

   mont_bitserial_mul #(.WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .b(b4), .m(m4),
      .a_bit(a_bit4), .a_valid(a_valid4), .a_ready(a_ready4),
      .busy(busy4), .done(done4), .result(result4)
   );

   mont_bitserial_mul #(.WIDTH(20)) u_dut20 (
      .clk(clk), .reset(reset), .start(start20), .b(b20), .m(m20),
      .a_bit(a_bit20), .a_valid(a_valid20), .a_ready(a_ready20),
      .busy(busy20), .done(done20), .result(result20)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] q4[$];
   logic [31:0] q20[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: the r in [0,m) with r*2^w == a*b (mod m).
   function automatic longint mont_ref(longint a, longint bb, longint mm, int w);
      longint ab = (a * bb) % mm;
      longint p  = (longint'(1) << w) % mm;
      for (longint r = 0; r < mm; r++)
         if ((r * p) % mm == ab) return r;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (done4) begin
         if (q4.size() == 0) check("done4_unexpected", 1, 0);
         else check("result4", result4, q4.pop_front());
      end
      if (done20) begin
         if (q20.size() == 0) check("done20_unexpected", 1, 0);
         else check("result20", result20, q20.pop_front());
      end
   end

   task automatic op4(input logic [3:0] a, input logic [3:0] bb, input logic [3:0] mm,
                      input int stall_at, input int stall_len, input int glitch_at,
                      input logic chk_s, input logic [23:0] es, input string tag);
      int edges;
      int exp_lat;
      q4.push_back(32'(mont_ref(a, bb, mm, 4)));
      start4 = 1'b1; b4 = bb; m4 = mm;
      @(posedge clk) #1;
      start4 = 1'b0; edges = 1;
      b4 = 4'($urandom); m4 = 4'($urandom);
      check({tag, "_busy"}, busy4, 1);
      for (int i = 0; i < 4; i++) begin
         if (i == stall_at) begin
            a_valid4 = 1'b0; a_bit4 = ~a[i];
            repeat (stall_len) begin
               check({tag, "_ready_stall"}, a_ready4, 1);
               @(posedge clk) #1;
               edges++;
            end
         end
         check($sformatf("%s_ready%0d", tag, i), a_ready4, 1);
         a_bit4 = a[i]; a_valid4 = 1'b1;
         if (i == glitch_at) begin
            start4 = 1'b1; b4 = ~bb; m4 = 4'hF;
         end
         @(posedge clk) #1;
         edges++;
         a_valid4 = 1'b0; start4 = 1'b0;
         if (chk_s) check($sformatf("%s_s%0d", tag, i), 32'(u_dut4.s_acc), 32'(es[6*i +: 6]));
      end
      check({tag, "_ready_off"}, a_ready4, 0);
      while (!done4 && edges < 30) begin
         @(posedge clk) #1;
         edges++;
      end
      exp_lat = 6 + ((stall_at >= 0 && stall_at < 4) ? stall_len : 0);
      check({tag, "_latency"}, edges, exp_lat);
      check({tag, "_busy_done"}, busy4, 0);
   endtask

   task automatic op20(input logic [19:0] a, input logic [19:0] bb, input logic [19:0] mm,
                       input string tag);
      int edges;
      q20.push_back(32'(mont_ref(a, bb, mm, 20)));
      start20 = 1'b1; b20 = bb; m20 = mm;
      @(posedge clk) #1;
      start20 = 1'b0; edges = 1;
      for (int i = 0; i < 20; i++) begin
         a_bit20 = a[i]; a_valid20 = 1'b1;
         @(posedge clk) #1;
         edges++;
      end
      a_valid20 = 1'b0;
      while (!done20 && edges < 60) begin
         @(posedge clk) #1;
         edges++;
      end
      check({tag, "_latency"}, edges, 22);
   endtask

   initial begin
      reset = 1'b1;
      start4 = 1'b0; a_bit4 = 1'b0; a_valid4 = 1'b0; b4 = '0; m4 = '0;
      start20 = 1'b0; a_bit20 = 1'b0; a_valid20 = 1'b0; b20 = '0; m20 = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_busy", busy4, 0);
      check("rst_done", done4, 0);
      check("rst_ready", a_ready4, 0);
      check("rst_result", result4, 0);
      check("rst_busy20", busy20, 0);

      op4(4'd5, 4'd7, 4'd13, -1, 0, -1, 1'b1, {6'd3, 6'd6, 6'd5, 6'd10}, "s1");
      @(posedge clk) #1;
      op4(4'd15, 4'd12, 4'd13, -1, 0, -1, 1'b1, {6'd21, 6'd17, 6'd9, 6'd6}, "s2");
      @(posedge clk) #1;
      op4(4'd5, 4'd7, 4'd13, 2, 3, -1, 1'b1, {6'd3, 6'd6, 6'd5, 6'd10}, "stall");
      @(posedge clk) #1;

      // Abort after the second accepted bit; no result is expected from it.
      start4 = 1'b1; b4 = 4'd7; m4 = 4'd13;
      @(posedge clk) #1;
      start4 = 1'b0; a_valid4 = 1'b1; a_bit4 = 1'b1;
      @(posedge clk) #1;
      a_bit4 = 1'b0;
      @(posedge clk) #1;
      a_valid4 = 1'b0; reset = 1'b1;
      @(posedge clk) #1;
      reset = 1'b0;
      check("abort_busy", busy4, 0);
      check("abort_done", done4, 0);
      check("abort_result", result4, 0);
      check("abort_ready", a_ready4, 0);
      repeat (3) @(posedge clk) #1;
      op4(4'd5, 4'd7, 4'd13, -1, 0, -1, 1'b1, {6'd3, 6'd6, 6'd5, 6'd10}, "s1r");
      @(posedge clk) #1;

      op4(4'd5, 4'd7, 4'd13, -1, 0, 1, 1'b1, {6'd3, 6'd6, 6'd5, 6'd10}, "glitch");
      @(posedge clk) #1;

      op4(4'd15, 4'd12, 4'd13, -1, 0, -1, 1'b0, 24'd0, "b2b_a");
      op4(4'd5, 4'd7, 4'd13, -1, 0, -1, 1'b0, 24'd0, "b2b_b");

      for (int k = 0; k < 8; k++) begin
         logic [3:0] mm, bb, aa;
         mm = 4'(2 * $urandom_range(1, 7) + 1);
         bb = 4'($urandom_range(0, 32'(mm) - 1));
         aa = 4'($urandom);
         @(posedge clk) #1;
         op4(aa, bb, mm, (k % 2 == 1) ? int'($urandom_range(0, 3)) : -1, 2, -1,
             1'b0, 24'd0, $sformatf("rnd%0d", k));
      end

      op20(20'($urandom), 20'd0, 20'hFFFFD, "w20_zero");
      @(posedge clk) #1;
      op20(20'($urandom), 20'h12345, 20'hFFFFD, "w20_rnd");

      repeat (4) @(posedge clk) #1;
      check("q4_drained", q4.size(), 0);
      check("q20_drained", q20.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
